// File: rtl/in12_kb_scanner_if.sv
// Signal bundle between the IN-12 scan engine and the display drivers and keyboard matrix.
// The master side is the scanner; the slave side supplies digit codes and keyboard rows.
interface in12_kb_scanner_if #(
    parameter int DIGITS  = 10,
    parameter int DIGIT_W = 4,
    parameter int ROWS    = 7
);
    logic [DIGITS*DIGIT_W-1:0] digit_data;
    logic [ROWS-1:0]           kb_row;
    logic [$clog2(DIGITS)-1:0] anode_idx;
    logic [DIGITS-1:0]         anode_sel;
    logic [DIGIT_W-1:0]        cathode;
    logic                      in12_clear;
    logic                      in12_write_anode;
    logic                      in12_write_cathode;
    logic                      keyboard_read;
    logic [DIGITS*ROWS-1:0]    keys_state;
    logic [DIGITS*ROWS-1:0]    key_press;
    logic                      frame_done;

    modport master (
        input  digit_data, kb_row,
        output anode_idx, anode_sel, cathode, in12_clear, in12_write_anode,
               in12_write_cathode, keyboard_read, keys_state, key_press, frame_done
    );

    modport slave (
        output digit_data, kb_row,
        input  anode_idx, anode_sel, cathode, in12_clear, in12_write_anode,
               in12_write_cathode, keyboard_read, keys_state, key_press, frame_done
    );
endinterface

// File: rtl/in12_kb_scanner.sv
// Slot-by-slot scan engine for the IN-12 nixie anodes with keyboard sampling and
// per-key frame-based debounce. All outputs are registered.
module in12_kb_scanner #(
    parameter int DIGITS       = 10,
    parameter int DIGIT_W      = 4,
    parameter int ROWS         = 7,
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 20,
    parameter int DEBOUNCE     = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Enable,
    in12_kb_scanner_if.master bus
);
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int IW = $clog2(DIGITS);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int NK = DIGITS * ROWS;

    localparam logic [CW-1:0]     C_LAST_BLANK = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]     C_PRE_SAMPLE = CW'(SLOT_CYCLES - 2);
    localparam logic [IW-1:0]     LAST_IDX     = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_SEL      = DIGITS'(1);
    localparam logic [DW-1:0]     DB_LAST      = DW'(DEBOUNCE - 1);

    typedef enum logic [2:0] {IDLE, BLANK, WR_A, WR_C, DWELL, SAMPLE} state_t;

    state_t              state;
    logic [CW-1:0]       c;
    logic [IW-1:0]       idx;
    logic [DIGITS-1:0]   sel;
    logic [DIGIT_W-1:0]  cathode;
    logic                clear;
    logic                wr_a;
    logic                wr_c;
    logic                kb_read;
    logic                frame;
    logic [NK-1:0]       keys;
    logic [NK-1:0]       press;

    // Registered outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            c       <= '0;
            idx     <= '0;
            sel     <= '0;
            cathode <= '0;
            clear   <= 1'b1;
            wr_a    <= 1'b0;
            wr_c    <= 1'b0;
            kb_read <= 1'b0;
            frame   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        state <= BLANK;
                        c     <= '0;
                    end
                end
                BLANK: begin
                    c <= c + 1'b1;
                    if (c == C_LAST_BLANK) begin
                        cathode <= bus.digit_data[int'(idx)*DIGIT_W +: DIGIT_W];
                        sel     <= ONE_SEL << idx;
                        clear   <= 1'b0;
                        wr_a    <= 1'b1;
                        state   <= WR_A;
                    end
                end
                WR_A: begin
                    c     <= c + 1'b1;
                    wr_a  <= 1'b0;
                    wr_c  <= 1'b1;
                    state <= WR_C;
                end
                WR_C: begin
                    c     <= c + 1'b1;
                    wr_c  <= 1'b0;
                    state <= DWELL;
                end
                DWELL: begin
                    c <= c + 1'b1;
                    if (c == C_PRE_SAMPLE) begin
                        kb_read <= 1'b1;
                        frame   <= (idx == LAST_IDX);
                        state   <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    c       <= '0;
                    kb_read <= 1'b0;
                    frame   <= 1'b0;
                    sel     <= '0;
                    clear   <= 1'b1;
                    idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    state   <= Enable ? BLANK : IDLE;
                end
                default: begin
                    state <= IDLE;
                    c     <= '0;
                    sel   <= '0;
                    clear <= 1'b1;
                end
            endcase
        end
    end

    // Each key only moves in the SAMPLE of its own column; a flip needs DEBOUNCE
    // consecutive disagreeing samples, and any agreeing sample restarts the count.
    for (genvar k = 0; k < NK; k++) begin : g_key
        localparam logic [IW-1:0] COL = IW'(k / ROWS);
        localparam int            ROW = k % ROWS;

        logic          st;
        logic          pr;
        logic [DW-1:0] cnt;

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                st  <= 1'b0;
                pr  <= 1'b0;
                cnt <= '0;
            end else begin
                pr <= 1'b0;
                if (state == SAMPLE && idx == COL) begin
                    if (bus.kb_row[ROW] == st) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        st  <= ~st;
                        pr  <= ~st;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign keys[k]  = st;
        assign press[k] = pr;
    end

    assign bus.anode_idx          = idx;
    assign bus.anode_sel          = sel;
    assign bus.cathode            = cathode;
    assign bus.in12_clear         = clear;
    assign bus.in12_write_anode   = wr_a;
    assign bus.in12_write_cathode = wr_c;
    assign bus.keyboard_read      = kb_read;
    assign bus.keys_state         = keys;
    assign bus.key_press          = press;
    assign bus.frame_done         = frame;
endmodule

// File: tb/tb_in12_kb_scanner.sv
// Scoreboard bench for in12_kb_scanner: the driver pushes per-slot expectations from a
// frame-level key model, and a negedge monitor pops them when the DUT samples the keyboard.
module tb_in12_kb_scanner;
    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;
    localparam int ROWS    = 3;
    localparam int SLOT    = 10;
    localparam int BLANK   = 2;
    localparam int DEB     = 2;
    localparam int NK      = DIGITS * ROWS;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      enable = 1'b0;
    logic [DIGITS*DIGIT_W-1:0] digit_data = '0;
    logic [ROWS-1:0]           kb_row = '0;

    in12_kb_scanner_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .ROWS(ROWS)) bus ();

    assign bus.digit_data = digit_data;
    assign bus.kb_row     = kb_row;

    in12_kb_scanner #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .ROWS(ROWS),
        .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .DEBOUNCE(DEB)
    ) dut (
        .Clk(clk), .Rst(rst), .Enable(enable), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] cath;
        logic [3:0] sel;
        logic       fd;
    } slot_t;

    typedef struct packed {
        logic [NK-1:0] keys;
        logic [NK-1:0] press;
    } key_t;

    slot_t slot_q[$];
    key_t  key_q[$];

    int total = 0;
    int bad = 0;
    int model_cnt[NK];
    bit model_state[NK];
    int col = 0;
    int stray_press = 0;
    logic [ROWS-1:0] prev_raw[DIGITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            model_cnt[i]   = 0;
            model_state[i] = 1'b0;
        end
    endtask

    // Drives one slot's inputs and pushes what the scanner must show at its SAMPLE.
    task automatic issue_slot(input logic [15:0] dd, input logic [ROWS-1:0] raw);
        slot_t s;
        key_t  k;
        digit_data = dd;
        kb_row     = raw;
        s.idx  = 2'(col);
        s.cath = dd[col*DIGIT_W +: DIGIT_W];
        s.sel  = 4'(1 << col);
        s.fd   = (col == DIGITS - 1);
        slot_q.push_back(s);
        k.press = '0;
        for (int r = 0; r < ROWS; r++) begin
            int kk;
            kk = col * ROWS + r;
            if (raw[r] == model_state[kk]) begin
                model_cnt[kk] = 0;
            end else begin
                model_cnt[kk]++;
                if (model_cnt[kk] == DEB) begin
                    model_state[kk] = !model_state[kk];
                    model_cnt[kk]   = 0;
                    if (model_state[kk]) k.press[kk] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NK; i++) k.keys[i] = model_state[i];
        key_q.push_back(k);
    endtask

    // Called at c=0 of a slot; returns at c=0 of the following slot.
    task automatic finish_slot(input bit drop);
        repeat (5) @(negedge clk);
        digit_data = ~digit_data;
        if (drop) enable = 1'b0;
        repeat (5) @(negedge clk);
        col = (col + 1) % DIGITS;
    endtask

    function automatic logic [ROWS-1:0] raw_directed(input int f, input int cc);
        if (cc == 2) return 3'b010;
        if (cc == 1 && f == 0) return 3'b001;
        return 3'b000;
    endfunction

    task automatic applyStimulus();
        int idle_bad;
        logic [ROWS-1:0] raw;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_anode_idx", bus.anode_idx, 0);
        check("rst_anode_sel", bus.anode_sel, 0);
        check("rst_cathode", bus.cathode, 0);
        check("rst_clear", bus.in12_clear, 1);
        check("rst_strobes", {bus.in12_write_anode, bus.in12_write_cathode, bus.keyboard_read, bus.frame_done}, 0);
        check("rst_keys", bus.keys_state, 0);
        check("rst_press", bus.key_press, 0);
        rst = 1'b0;

        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.in12_write_anode || bus.in12_write_cathode || bus.keyboard_read ||
                bus.frame_done || bus.anode_sel != '0 || !bus.in12_clear || bus.anode_idx != '0)
                idle_bad++;
        end
        check("idle_cycles_bad", idle_bad, 0);

        enable = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < DIGITS; s++) begin
                issue_slot((f == 0) ? 16'h4321 : 16'($urandom), raw_directed(f, col));
                finish_slot(1'b0);
            end
        end

        issue_slot(16'($urandom), 3'b000);
        finish_slot(1'b0);
        issue_slot(16'($urandom), 3'b000);
        finish_slot(1'b1);
        check("drop_idx", bus.anode_idx, 2);
        check("drop_clear", bus.in12_clear, 1);
        check("drop_sel", bus.anode_sel, 0);
        repeat (5) @(negedge clk);
        check("drop_still_idle", {bus.in12_write_anode, bus.anode_sel}, 0);

        enable = 1'b1;
        @(negedge clk);
        for (int s = 0; s < DIGITS; s++) begin
            issue_slot(16'($urandom), raw_directed(9, col));
            finish_slot(1'b0);
        end

        issue_slot(16'($urandom), raw_directed(9, col));
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_keys", bus.keys_state, 0);
        check("arst_sel", bus.anode_sel, 0);
        check("arst_clear", bus.in12_clear, 1);
        check("arst_idx", bus.anode_idx, 0);
        check("arst_press", bus.key_press, 0);
        slot_q.delete();
        key_q.delete();
        model_reset();
        col = 0;
        for (int i = 0; i < DIGITS; i++) prev_raw[i] = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < DIGITS; s++) begin
                if ($urandom_range(0, 1) == 1) raw = prev_raw[col];
                else raw = 3'($urandom);
                prev_raw[col] = raw;
                issue_slot(16'($urandom), raw);
                finish_slot((f == 7) && (s == DIGITS - 1));
            end
        end
        repeat (5) @(negedge clk);
    endtask

    int    cyc = 0;
    int    last_wa = 0;
    int    last_wc = 0;
    int    last_fd = -1;
    bit    key_pending = 1'b0;
    logic [DIGITS-1:0] prev_sel = '0;
    logic  prev_clear = 1'b1;

    // Monitor: pops the scoreboard at each keyboard_read and on the cycle after it.
    always @(negedge clk) begin
        slot_t se;
        key_t  ke;
        if (rst) begin
            key_pending = 1'b0;
            last_fd     = -1;
            prev_sel    = '0;
            prev_clear  = 1'b1;
        end else begin
            cyc++;
            if (key_pending) begin
                key_pending = 1'b0;
                if (key_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL key_queue: got update with no expectation want queued entry");
                end else begin
                    ke = key_q.pop_front();
                    check("keys_state", 32'(bus.keys_state), 32'(ke.keys));
                    check("key_press", 32'(bus.key_press), 32'(ke.press));
                end
            end else if (bus.key_press != '0) begin
                stray_press++;
            end
            if (bus.in12_write_anode) begin
                last_wa = cyc;
                check("blank_before_anode", {prev_clear, prev_sel}, 5'b10000);
            end
            if (bus.in12_write_cathode) last_wc = cyc;
            if (bus.keyboard_read) begin
                key_pending = 1'b1;
                if (slot_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_sample: got keyboard_read=1 want no sample");
                end else begin
                    se = slot_q.pop_front();
                    check("anode_idx", bus.anode_idx, se.idx);
                    check("cathode", bus.cathode, se.cath);
                    check("anode_sel", bus.anode_sel, se.sel);
                    check("frame_done", bus.frame_done, se.fd);
                    check("clear_in_sample", bus.in12_clear, 0);
                    check("anode_to_read", cyc - last_wa, SLOT - 1 - BLANK);
                    check("anode_to_cathode", last_wc - last_wa, 1);
                end
            end
            if (bus.frame_done) begin
                if (last_fd >= 0) check("frame_period", cyc - last_fd, DIGITS * SLOT);
                last_fd = cyc;
            end
            if (!enable) last_fd = -1;
            prev_sel   = bus.anode_sel;
            prev_clear = bus.in12_clear;
        end
    end

    task automatic checkOutput();
        check("slot_q_left", slot_q.size(), 0);
        check("key_q_left", key_q.size(), 0);
        check("stray_press", stray_press, 0);
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
